pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
Measures an incoming PWM/pulse line, such as an ultrasonic echo or an external PWM source, in units of clk cycles. It reports the high time and the full period (rising edge to rising edge) of each completed cycle. It is the receive-side counterpart of the team's PWM generator, which drives a line from period/compare values. It sits between an asynchronous input pin and a register/CPU interface or a distance-calculation block.

Parameters:
WIDTH, 16, bit width of the counters and the measurement outputs.
SYNC_STAGES, 2, number of input synchronizer flops (minimum 2).

Ports:
clk  input  1  system clock; the single clock domain.
rst  input  1  reset; synchronous, active-high.
en  input  1  measurement enable; low forces IDLE.
line_in  input  1  asynchronous PWM input.
period_out  output  WIDTH  last completed period in clk cycles.
high_out  output  WIDTH  last completed high time in clk cycles.
valid  output  1  one-cycle pulse when period_out/high_out update.
timeout  output  1  one-cycle pulse when the counter saturates with no closing edge.
measuring  output  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All sync flops, the previous-level register, both counters, period_out, high_out, valid, timeout and measuring go to 0.
  - FSM goes to IDLE.
  - Reset mid-measurement discards the partial measurement.
- Input conditioning:
  - line_in passes through SYNC_STAGES flops to give ls.
  - lp holds ls delayed one cycle.
  - rise = ls & ~lp; fall = ~ls & lp. Both are combinational from registers.
- Counters: pcnt (period) and hcnt (high), each WIDTH bits and unsigned.
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - pcnt = hcnt = 0.
  - On rise with en=1: go to HIGH, pcnt <= 1, hcnt <= 1.
  - A falling edge seen in IDLE is ignored.
- HIGH, each cycle:
  - No fall: pcnt++, hcnt++.
  - On fall: go to LOW, pcnt++, hcnt holds.
- LOW, each cycle:
  - No rise: pcnt++.
  - On rise: period_out <= pcnt, high_out <= hcnt, valid <= 1, pcnt <= 1, hcnt <= 1, go to HIGH.
  - Measurement is back-to-back; no cycle is lost.
- Counting convention: the cycle in which rise is detected counts as cycle 1. Example: a line high for 5 cycles and low for 7 gives period_out=12, high_out=5.
- Minimum resolvable waveform: 1 cycle high, 1 cycle low, giving period 2 and high 1.
- Latency:
  - valid is registered.
  - With SYNC_STAGES=2, valid is high in the cycle following the 3rd clk edge after the closing rising edge of line_in meets setup.
  - In general the latency is SYNC_STAGES+1 edges.
- Saturation and timeout:
  - In HIGH or LOW, when pcnt == 2^WIDTH-1 and no publishing rise occurs in that cycle: timeout <= 1 for one cycle, FSM goes to IDLE, counters clear.
  - period_out and high_out hold their previous values; valid stays 0.
  - Simultaneous case: a rise in LOW in the same cycle that pcnt == max publishes normally (period_out = max) and does not time out.
  - A rise while in IDLE after a timeout starts a fresh measurement.
- Enable:
  - en=0 forces IDLE next cycle and clears counters.
  - No valid or timeout pulse is produced while en=0.
  - Outputs hold.
  - The sync chain keeps running, so the edge detector remains correct when en is re-asserted.
  - After en rises, the first valid requires two observed rising edges.
- Pulse and level rules: valid and timeout are never both 1 in the same cycle. measuring = (state != IDLE), registered with the state.
- Outputs change only on a valid cycle, on rst, or never.

Test Plan:
1. Reset: hold rst 3 cycles with line_in toggling → all outputs 0; measuring=0.
2. Steady stream, 5 high / 7 low, repeated 4 periods → first valid at the second rising edge +3 clk edges, period_out=12, high_out=5; valid then pulses every 12 cycles with identical values.
3. Duty change, 3 high / 9 low followed by 1 high / 1 low → period_out=12, high_out=3, then period_out=2, high_out=1 on consecutive valids without missed cycles.
4. Stuck high, WIDTH=8, one rising edge then line held high → timeout pulses once when pcnt hits 255; FSM returns to IDLE; period_out/high_out unchanged; no valid.
5. Enable drop: deassert en mid-HIGH for 4 cycles, then re-enable with the 5/7 stream → no valid during disable; first valid only after two post-enable rising edges, value 12/5.
6. Reset mid-LOW: assert rst for 1 cycle during a period → no valid for the interrupted period; outputs 0; the next full 5/7 period measures 12/5.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rise-to-rise period of an asynchronous pulse line in clk cycles.
// Results publish back-to-back on each closing rising edge; a saturated period counter reports a timeout.
module pwm_capture #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             line_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             valid,
    output logic             timeout,
    output logic             measuring
);
    localparam logic [1:0]       IDLE = 2'd0;
    localparam logic [1:0]       HIGH = 2'd1;
    localparam logic [1:0]       LOW  = 2'd2;
    localparam logic [WIDTH-1:0] MAX  = '1;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync;
    logic                   lp;
    logic                   ls;
    logic                   rise;
    logic                   fall;
    logic [1:0]             state;
    logic [WIDTH-1:0]       pcnt;
    logic [WIDTH-1:0]       hcnt;

    assign ls        = sync[SYNC_STAGES-1];
    assign rise      = ls & ~lp;
    assign fall      = ~ls & lp;
    assign measuring = (state != IDLE);

    // The sync chain and edge history keep running while disabled so edges stay coherent on re-enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            lp   <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], line_in};
            lp   <= ls;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pcnt       <= '0;
            hcnt       <= '0;
            period_out <= '0;
            high_out   <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid   <= 1'b0;
            timeout <= 1'b0;
            if (!en) begin
                state <= IDLE;
                pcnt  <= '0;
                hcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= rise ? HIGH : IDLE;
                        pcnt  <= rise ? ONE : '0;
                        hcnt  <= rise ? ONE : '0;
                    end
                    HIGH: begin
                        if (pcnt == MAX) begin
                            state   <= IDLE;
                            pcnt    <= '0;
                            hcnt    <= '0;
                            timeout <= 1'b1;
                        end else begin
                            state <= fall ? LOW : HIGH;
                            pcnt  <= pcnt + 1'b1;
                            hcnt  <= fall ? hcnt : hcnt + 1'b1;
                        end
                    end
                    LOW: begin
                        // A closing rise wins over saturation so a max-length period still publishes.
                        if (rise) begin
                            state      <= HIGH;
                            period_out <= pcnt;
                            high_out   <= hcnt;
                            valid      <= 1'b1;
                            pcnt       <= ONE;
                            hcnt       <= ONE;
                        end else if (pcnt == MAX) begin
                            state   <= IDLE;
                            pcnt    <= '0;
                            hcnt    <= '0;
                            timeout <= 1'b1;
                        end else begin
                            pcnt <= pcnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        pcnt  <= '0;
                        hcnt  <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives a 16-bit and an 8-bit capture unit from one line, checking both against
// a timestamp-based reference model every cycle plus directed vectors for the listed scenarios.
module tb_pwm_capture;
    localparam int S = 2;

    logic        clk, rst, en, line_in;
    logic [15:0] p16, h16;
    logic        v16, t16, m16;
    logic [7:0]  p8, h8;
    logic        v8, t8, m8;

    pwm_capture #(.WIDTH(16), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .en(en), .line_in(line_in),
        .period_out(p16), .high_out(h16), .valid(v16), .timeout(t16), .measuring(m16)
    );

    pwm_capture #(.WIDTH(8), .SYNC_STAGES(S)) dut8 (
        .clk(clk), .rst(rst), .en(en), .line_in(line_in),
        .period_out(p8), .high_out(h8), .valid(v8), .timeout(t8), .measuring(m8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: line as seen after the synchronizer, then timestamps of rise/fall events.
    logic hq [0:S];
    bit   armed [2];
    bit   seen_fall [2];
    int   t0 [2];
    int   tf [2];
    int   ep [2];
    int   eh [2];
    bit   ev [2];
    bit   et [2];
    int   maxv [2] = '{65535, 255};

    logic [31:0] obs16 [$];
    int v16_cnt = 0, v8_cnt = 0, to8_cnt = 0;
    int r_hi, r_lo, snap_v, snap_v8, snap_t8;

    typedef struct {
        int hi;
        int lo;
        int exp_p;
        int exp_h;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int m, input bit r, input bit e, input bit ri, input bit fa);
        ev[m] = 1'b0;
        et[m] = 1'b0;
        if (r) begin
            armed[m] = 1'b0;
            ep[m] = 0;
            eh[m] = 0;
        end else if (!e) begin
            armed[m] = 1'b0;
        end else if (!armed[m]) begin
            if (ri) begin
                armed[m] = 1'b1;
                seen_fall[m] = 1'b0;
                t0[m] = cyc;
            end
        end else if (ri && seen_fall[m]) begin
            ep[m] = cyc - t0[m];
            eh[m] = tf[m] - t0[m];
            ev[m] = 1'b1;
            t0[m] = cyc;
            seen_fall[m] = 1'b0;
        end else if (cyc - t0[m] == maxv[m]) begin
            et[m] = 1'b1;
            armed[m] = 1'b0;
        end else if (fa && !seen_fall[m]) begin
            seen_fall[m] = 1'b1;
            tf[m] = cyc;
        end
    endtask

    task automatic tick(input logic l, input logic e, input logic r);
        logic ls_m, lp_m;
        line_in = l;
        en = e;
        rst = r;
        ls_m = hq[S-1];
        lp_m = hq[S];
        for (int m = 0; m < 2; m++) model_step(m, r, e, ls_m & ~lp_m, ~ls_m & lp_m);
        if (r) begin
            for (int i = 0; i <= S; i++) hq[i] = 1'b0;
        end else begin
            for (int i = S; i > 0; i--) hq[i] = hq[i-1];
            hq[0] = l;
        end
        cyc++;
        @(negedge clk);
        check("cycle16", {p16, h16, v16, t16, m16},
              {16'(ep[0]), 16'(eh[0]), ev[0], et[0], armed[0]});
        check("cycle8", {p8, h8, v8, t8, m8},
              {8'(ep[1]), 8'(eh[1]), ev[1], et[1], armed[1]});
        if (v16) begin
            obs16.push_back({p16, h16});
            v16_cnt++;
        end
        if (v8) v8_cnt++;
        if (t8) to8_cnt++;
    endtask

    task automatic seg(input int hi, input int lo);
        repeat (hi) tick(1'b1, 1'b1, 1'b0);
        repeat (lo) tick(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        tbl[0] = '{5, 7, 12, 5};
        tbl[1] = '{5, 7, 12, 5};
        tbl[2] = '{5, 7, 12, 5};
        tbl[3] = '{5, 7, 12, 5};
        tbl[4] = '{3, 9, 12, 3};
        tbl[5] = '{1, 1, 2, 1};
        tbl[6] = '{1, 1, 2, 1};
        for (int i = 0; i <= S; i++) hq[i] = 1'b0;

        // Reset with the line toggling
        for (int i = 0; i < 3; i++) tick(1'(i % 2), 1'b1, 1'b1);
        check("reset16", {p16, h16, v16, t16, m16}, 35'd0);
        check("reset8", {p8, h8, v8, t8, m8}, 19'd0);
        repeat (4) tick(1'b0, 1'b1, 1'b0);

        // Steady stream then duty changes, closed by one extra rise
        obs16.delete();
        for (int i = 0; i < 7; i++) seg(tbl[i].hi, tbl[i].lo);
        tick(1'b1, 1'b1, 1'b0);
        repeat (6) tick(1'b0, 1'b1, 1'b0);
        check("table count", obs16.size(), 7);
        for (int i = 0; i < 7 && i < obs16.size(); i++)
            check($sformatf("table[%0d]", i), obs16[i], {16'(tbl[i].exp_p), 16'(tbl[i].exp_h)});

        // Stuck high on the 8-bit unit: one timeout, outputs hold, no valid
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        snap_v8 = v8_cnt;
        snap_t8 = to8_cnt;
        repeat (300) tick(1'b1, 1'b1, 1'b0);
        check("stuck timeouts", to8_cnt - snap_t8, 1);
        check("stuck valids", v8_cnt - snap_v8, 0);
        check("stuck period", p8, 8'd2);
        check("stuck high", h8, 8'd1);
        check("stuck idle", m8, 1'b0);
        check("stuck wide busy", m16, 1'b1);
        repeat (10) tick(1'b0, 1'b1, 1'b0);

        // Enable drop mid-HIGH
        seg(5, 7);
        seg(5, 7);
        repeat (4) tick(1'b1, 1'b1, 1'b0);
        snap_v = v16_cnt;
        repeat (4) tick(1'b1, 1'b0, 1'b0);
        check("disable valids", v16_cnt - snap_v, 0);
        check("disable idle", m16, 1'b0);
        obs16.delete();
        repeat (3) tick(1'b1, 1'b1, 1'b0);
        repeat (7) tick(1'b0, 1'b1, 1'b0);
        seg(5, 7);
        check("reenable one rise", obs16.size(), 0);
        seg(5, 7);
        seg(5, 7);
        check("reenable count", obs16.size(), 2);
        if (obs16.size() > 0) check("reenable first", obs16[0], {16'd12, 16'd5});

        // Reset mid-LOW discards the partial period
        seg(5, 7);
        repeat (5) tick(1'b1, 1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        check("midreset16", {p16, h16, v16, t16, m16}, 35'd0);
        obs16.delete();
        repeat (4) tick(1'b0, 1'b1, 1'b0);
        seg(5, 7);
        seg(5, 7);
        tick(1'b1, 1'b1, 1'b0);
        repeat (6) tick(1'b0, 1'b1, 1'b0);
        check("post reset count", obs16.size(), 2);
        if (obs16.size() > 0) check("post reset first", obs16[0], {16'd12, 16'd5});

        // Random waveforms with occasional enable drops, resets and long highs
        for (int k = 0; k < 150; k++) begin
            r_hi = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 20);
            r_lo = $urandom_range(1, 20);
            repeat (r_hi) tick(1'b1, $urandom_range(0, 39) != 0, $urandom_range(0, 399) == 0);
            repeat (r_lo) tick(1'b0, $urandom_range(0, 39) != 0, $urandom_range(0, 399) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
